pipe_stage_buf: RTL and testbench

Parametrised valid/ready pipeline stage register placed between adjacent stages of the NPC core. Typical placements are IF->ID, ID->EX and EX->WB. It replaces the hard-wired single-cycle pass-through stage with a mode-selectable stage that offers three options: bypass, half-throughput register, or full-throughput skid buffer. It also adds a synchronous flush for branch/exception redirect. The payload is opaque; the default width carries {pc, snpc, inst}.

---
 rtl/pipe_stage_buf_pkg.sv | 38 +++
 rtl/pipe_stage_buf_if.sv | 36 +++
 rtl/pipe_stage_fsm.sv | 132 +++++++++++++
 rtl/pipe_stage_buf.sv | 84 ++++++++
 tb/tb_pipe_stage_buf.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_stage_buf_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the NPC pipeline stage register (pipe_stage_buf).
//   - MODE_* : stage operating modes (bypass, half-rate register, skid buffer)
//   - stage_state_e : 2-bit stage state; the encoding equals the number of
//     held entries, so the occupancy count falls straight out of the state
//   - *_LSB : bit offsets of the default {pc, snpc, inst} payload fields
//   - PC_RESET : pc value placed in the top word of every data register on reset
// -----------------------------------------------------------------------------
package pipe_pkg;

   localparam int MODE_BYPASS = 0;
   localparam int MODE_REG    = 1;
   localparam int MODE_SKID   = 2;

   // MODE 2 uses all three states; MODE 1 only uses the first two, under the
   // IDLE/FULL1 aliases below.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_BUSY  = 2'd1,
      ST_FULL2 = 2'd2
   } stage_state_e;

   localparam stage_state_e ST_IDLE  = ST_EMPTY;
   localparam stage_state_e ST_FULL1 = ST_BUSY;

   localparam int INST_LSB = 0;
   localparam int SNPC_LSB = 32;
   localparam int PC_LSB   = 64;

   localparam logic [31:0] PC_RESET = 32'h8000_0000;

   // The state value is the number of entries held by the stage.
   function automatic logic [1:0] state_count(input stage_state_e st);
      return st;
   endfunction

endpackage

// File: rtl/pipe_stage_buf_if.sv
// -----------------------------------------------------------------------------
// pipe_stage_buf_if
// Bundles the valid/ready handshake on both sides of one pipeline stage,
// together with the redirect flush and the occupancy count.
//   flush   : drop buffered entries and any same-cycle input
//   s_*     : upstream side (s_valid/s_data in, s_ready out of the stage)
//   m_*     : downstream side (m_valid/m_data out, m_ready in to the stage)
//   count   : number of entries currently held by the stage
// Modports:
//   slave   : the stage itself
//   master  : the surrounding pipeline that drives the stage
// -----------------------------------------------------------------------------
interface pipe_stage_buf_if #(
   parameter int DATA_W = 96
);

   logic              flush;
   logic              s_valid;
   logic              s_ready;
   logic [DATA_W-1:0] s_data;
   logic              m_valid;
   logic              m_ready;
   logic [DATA_W-1:0] m_data;
   logic [1:0]        count;

   modport master (
      output flush, s_valid, s_data, m_ready,
      input  s_ready, m_valid, m_data, count
   );

   modport slave (
      input  flush, s_valid, s_data, m_ready,
      output s_ready, m_valid, m_data, count
   );

endinterface

// File: rtl/pipe_stage_fsm.sv
// -----------------------------------------------------------------------------
// pipe_stage_fsm
// Control path of pipe_stage_buf for MODE 1 (IDLE/FULL1 register) and
// MODE 2 (EMPTY/BUSY/FULL2 skid buffer). Owns the state register, the
// registered handshake outputs and the load enables for the data registers.
// Ports:
//   clk, rst        : clock, synchronous active-low reset
//   flush           : abandon everything held and any same-cycle input
//   s_valid, m_ready: handshake inputs from upstream / downstream
//   s_ready, m_valid: handshake outputs (registered, no path from m_ready)
//   count           : entries held (0..1 in MODE 1, 0..2 in MODE 2)
//   load_main       : main register captures this cycle
//   load_skid       : skid register captures s_data this cycle
//   main_from_skid  : main register is refilled from skid instead of s_data
// -----------------------------------------------------------------------------
module pipe_stage_fsm
   import pipe_pkg::*;
#(
   parameter int MODE = MODE_SKID
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       flush,
   input  logic       s_valid,
   input  logic       m_ready,
   output logic       s_ready,
   output logic       m_valid,
   output logic [1:0] count,
   output logic       load_main,
   output logic       load_skid,
   output logic       main_from_skid
);

   stage_state_e state;
   stage_state_e nxt_state;
   logic         s_ready_q;
   logic         in_xfer;
   logic         out_xfer;

   // s_ready_q is precomputed for the state being entered, so it is already 1
   // in the first cycle after reset release; gating with rst keeps the stage
   // closed to upstream for the whole time reset is held.
   assign s_ready  = s_ready_q & rst;
   assign in_xfer  = s_valid & s_ready;
   assign out_xfer = m_valid & m_ready;

   // Transition rules. Flush beats every transfer; an output transfer in the
   // flush cycle still completes downstream because m_valid/m_data are
   // already presented.
   function automatic stage_state_e next_state(
      input stage_state_e st,
      input logic         f,
      input logic         i,
      input logic         o
   );
      stage_state_e n;
      n = st;
      if (f) begin
         n = ST_EMPTY;
      end else if (MODE == MODE_REG) begin
         case (st)
            ST_IDLE:  if (i) n = ST_FULL1;
            ST_FULL1: if (o) n = ST_IDLE;
            default:  n = ST_IDLE;
         endcase
      end else begin
         case (st)
            ST_EMPTY: if (i) n = ST_BUSY;
            ST_BUSY: begin
               if (i & ~o) begin
                  n = ST_FULL2;
               end else if (~i & o) begin
                  n = ST_EMPTY;
               end
            end
            ST_FULL2: if (o) n = ST_BUSY;
            default:  n = ST_EMPTY;
         endcase
      end
      return n;
   endfunction

   assign nxt_state = next_state(state, flush, in_xfer, out_xfer);

   // Data register load enables. Nothing is captured in a flush cycle, so a
   // discarded input never overwrites the held payload. In BUSY with both
   // transfers the old head leaves as the new item takes its place; without
   // an output the new item parks in skid. In FULL2 skid moves up on output.
   always_comb begin
      load_main      = 1'b0;
      load_skid      = 1'b0;
      main_from_skid = 1'b0;
      if (!flush) begin
         case (state)
            ST_EMPTY: begin
               load_main = in_xfer;
            end
            ST_BUSY: begin
               if (MODE == MODE_SKID) begin
                  load_main = in_xfer & out_xfer;
                  load_skid = in_xfer & ~out_xfer;
               end
            end
            ST_FULL2: begin
               load_main      = out_xfer;
               main_from_skid = out_xfer;
            end
            default: begin
               load_main = 1'b0;
            end
         endcase
      end
   end

   // State register. Handshake outputs and count are derived from the state
   // being entered, so they are plain flops at the module boundary.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= ST_EMPTY;
         s_ready_q <= 1'b1;
         m_valid   <= 1'b0;
         count     <= 2'd0;
      end else begin
         state     <= nxt_state;
         s_ready_q <= (MODE == MODE_REG) ? (nxt_state == ST_IDLE)
                                         : (nxt_state != ST_FULL2);
         m_valid   <= (nxt_state != ST_EMPTY);
         count     <= state_count(nxt_state);
      end
   end

endmodule

// File: rtl/pipe_stage_buf.sv
// -----------------------------------------------------------------------------
// pipe_stage_buf
// Mode-selectable valid/ready stage register placed between NPC pipeline
// stages (IF->ID, ID->EX, EX->WB). The payload is opaque; the default width
// carries {pc, snpc, inst}.
// Parameters:
//   DATA_W     : payload width
//   MODE       : 0 combinational bypass, 1 single register (1 item / 2 cycles),
//                2 two-entry skid buffer (1 item / cycle)
//   RESET_DATA : value of every data register after reset
// Ports:
//   clk  : clock, all state updates on the rising edge
//   rst  : synchronous active-low reset
//   bus  : handshake bundle (slave view): flush, s_valid/s_ready/s_data,
//          m_valid/m_ready/m_data, count
// -----------------------------------------------------------------------------
module pipe_stage_buf
   import pipe_pkg::*;
#(
   parameter int                DATA_W     = 96,
   parameter int                MODE       = MODE_SKID,
   parameter logic [DATA_W-1:0] RESET_DATA = {PC_RESET, 64'h0}
) (
   input logic              clk,
   input logic              rst,
   pipe_stage_buf_if.slave  bus
);

   generate
      if (MODE == MODE_BYPASS) begin : g_bypass

         // Pure wires: a flush swallows the incoming item by claiming it was
         // accepted while hiding it from downstream.
         assign bus.m_valid = bus.s_valid & ~bus.flush;
         assign bus.s_ready = bus.m_ready | bus.flush;
         assign bus.m_data  = bus.s_data;
         assign bus.count   = 2'd0;

      end else begin : g_buf

         logic              load_main;
         logic              load_skid;
         logic              main_from_skid;
         logic [DATA_W-1:0] main_q;
         logic [DATA_W-1:0] skid_q;

         pipe_stage_fsm #(
            .MODE (MODE)
         ) u_fsm (
            .clk            (clk),
            .rst            (rst),
            .flush          (bus.flush),
            .s_valid        (bus.s_valid),
            .m_ready        (bus.m_ready),
            .s_ready        (bus.s_ready),
            .m_valid        (bus.m_valid),
            .count          (bus.count),
            .load_main      (load_main),
            .load_skid      (load_skid),
            .main_from_skid (main_from_skid)
         );

         // Payload registers. Only the control path is cleared by flush;
         // the data simply goes stale behind a deasserted m_valid.
         always_ff @(posedge clk) begin
            if (!rst) begin
               main_q <= RESET_DATA;
               skid_q <= RESET_DATA;
            end else begin
               if (load_skid) begin
                  skid_q <= bus.s_data;
               end
               if (load_main) begin
                  main_q <= main_from_skid ? skid_q : bus.s_data;
               end
            end
         end

         assign bus.m_data = main_q;

      end
   endgenerate

endmodule

// File: tb/tb_pipe_stage_buf.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_buf
// Drives one stimulus stream into three pipe_stage_buf instances (MODE 0, 1
// and 2) and compares them to a queue-based reference: a stage of capacity N
// is an in-order queue that accepts while it holds fewer than N items, shows
// its head downstream, and empties on flush or reset.
// -----------------------------------------------------------------------------
module tb_pipe_stage_buf;

   localparam int          W        = 96;
   localparam logic [31:0] PC_RESET = 32'h8000_0000;

   logic         clk     = 1'b0;
   logic         rst     = 1'b0;
   logic         flush   = 1'b0;
   logic         s_valid = 1'b0;
   logic         m_ready = 1'b0;
   logic [W-1:0] s_data  = '0;

   int checks = 0;
   int passes = 0;

   logic [W-1:0] q1[$];
   logic [W-1:0] q2[$];

   typedef struct {
      logic         flush;
      logic         s_valid;
      logic [W-1:0] s_data;
      logic         m_ready;
      logic         exp_s_ready;
      logic         exp_m_valid;
      logic [W-1:0] exp_m_data;
      logic [1:0]   exp_count;
   } vec_t;

   vec_t vecs[$];

   always #5 clk = ~clk;

   pipe_stage_buf_if #(.DATA_W(W)) if0 ();
   pipe_stage_buf_if #(.DATA_W(W)) if1 ();
   pipe_stage_buf_if #(.DATA_W(W)) if2 ();

   assign if0.flush   = flush;
   assign if0.s_valid = s_valid;
   assign if0.s_data  = s_data;
   assign if0.m_ready = m_ready;
   assign if1.flush   = flush;
   assign if1.s_valid = s_valid;
   assign if1.s_data  = s_data;
   assign if1.m_ready = m_ready;
   assign if2.flush   = flush;
   assign if2.s_valid = s_valid;
   assign if2.s_data  = s_data;
   assign if2.m_ready = m_ready;

   pipe_stage_buf #(.DATA_W(W), .MODE(0)) u_dut0 (.clk(clk), .rst(rst), .bus(if0));
   pipe_stage_buf #(.DATA_W(W), .MODE(1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));
   pipe_stage_buf #(.DATA_W(W), .MODE(2)) u_dut2 (.clk(clk), .rst(rst), .bus(if2));

   task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
      checks++;
      if (got !== exp) begin
         $display("[TB] FAIL %s: got %h, expected %h", name, got, exp);
      end else begin
         passes++;
      end
   endtask

   // Inputs change on the falling edge; outputs are sampled 1 ns later.
   task automatic applyStimulus(input logic r, input logic f, input logic sv,
                                input logic [W-1:0] d, input logic mr);
      @(negedge clk);
      rst     = r;
      flush   = f;
      s_valid = sv;
      s_data  = d;
      m_ready = mr;
      #1;
   endtask

   task automatic checkBuf(input int mode, input int sz, input logic [W-1:0] head,
                           input logic sr, input logic mv, input logic [W-1:0] md,
                           input logic [1:0] cnt);
      check($sformatf("m%0d.s_ready", mode), W'(sr), W'(rst && (sz < mode)));
      check($sformatf("m%0d.m_valid", mode), W'(mv), W'(sz > 0));
      check($sformatf("m%0d.count", mode), W'(cnt), W'(sz));
      if (sz > 0) begin
         check($sformatf("m%0d.m_data", mode), md, head);
      end
   endtask

   task automatic checkOutput();
      check("m0.m_valid", W'(if0.m_valid), W'(s_valid & ~flush));
      check("m0.s_ready", W'(if0.s_ready), W'(m_ready | flush));
      check("m0.m_data", if0.m_data, s_data);
      check("m0.count", W'(if0.count), W'(0));
      checkBuf(1, q1.size(), (q1.size() > 0) ? q1[0] : '0,
               if1.s_ready, if1.m_valid, if1.m_data, if1.count);
      checkBuf(2, q2.size(), (q2.size() > 0) ? q2[0] : '0,
               if2.s_ready, if2.m_valid, if2.m_data, if2.count);
   endtask

   // Advances the reference queues across one rising edge.
   task automatic advance();
      bit in1, out1, in2, out2;
      in1  = rst && s_valid && (q1.size() < 1);
      out1 = m_ready && (q1.size() > 0);
      in2  = rst && s_valid && (q2.size() < 2);
      out2 = m_ready && (q2.size() > 0);
      @(posedge clk);
      if (!rst || flush) begin
         q1.delete();
         q2.delete();
      end else begin
         if (out1) void'(q1.pop_front());
         if (in1) q1.push_back(s_data);
         if (out2) void'(q2.pop_front());
         if (in2) q2.push_back(s_data);
      end
   endtask

   initial begin
      // MODE 2 directed table: inputs for the cycle, then the outputs
      // expected before that cycle's rising edge.
      // streaming 1..8 with m_ready high
      vecs.push_back('{1'b0, 1'b1, W'(1), 1'b1, 1'b1, 1'b0, W'(0), 2'd0});
      for (int k = 2; k <= 8; k++) begin
         vecs.push_back('{1'b0, 1'b1, W'(k), 1'b1, 1'b1, 1'b1, W'(k - 1), 2'd1});
      end
      vecs.push_back('{1'b0, 1'b0, W'(0), 1'b1, 1'b1, 1'b1, W'(8), 2'd1});
      vecs.push_back('{1'b0, 1'b0, W'(0), 1'b1, 1'b1, 1'b0, W'(0), 2'd0});
      // backpressure: 0xA, 0xB held, then drained
      vecs.push_back('{1'b0, 1'b1, W'('hA), 1'b0, 1'b1, 1'b0, W'(0), 2'd0});
      vecs.push_back('{1'b0, 1'b1, W'('hB), 1'b0, 1'b1, 1'b1, W'('hA), 2'd1});
      vecs.push_back('{1'b0, 1'b0, W'(0), 1'b0, 1'b0, 1'b1, W'('hA), 2'd2});
      vecs.push_back('{1'b0, 1'b0, W'(0), 1'b1, 1'b0, 1'b1, W'('hA), 2'd2});
      vecs.push_back('{1'b0, 1'b0, W'(0), 1'b1, 1'b1, 1'b1, W'('hB), 2'd1});
      vecs.push_back('{1'b0, 1'b0, W'(0), 1'b0, 1'b1, 1'b0, W'(0), 2'd0});
      // flush while full, with 0xC offered at the same time
      vecs.push_back('{1'b0, 1'b1, W'('hA), 1'b0, 1'b1, 1'b0, W'(0), 2'd0});
      vecs.push_back('{1'b0, 1'b1, W'('hB), 1'b0, 1'b1, 1'b1, W'('hA), 2'd1});
      vecs.push_back('{1'b1, 1'b1, W'('hC), 1'b0, 1'b0, 1'b1, W'('hA), 2'd2});
      vecs.push_back('{1'b0, 1'b0, W'(0), 1'b1, 1'b1, 1'b0, W'(0), 2'd0});
      vecs.push_back('{1'b0, 1'b0, W'(0), 1'b1, 1'b1, 1'b0, W'(0), 2'd0});
      // flush discarding a same-cycle accepted input (0xE)
      vecs.push_back('{1'b0, 1'b1, W'('hD), 1'b0, 1'b1, 1'b0, W'(0), 2'd0});
      vecs.push_back('{1'b1, 1'b1, W'('hE), 1'b0, 1'b1, 1'b1, W'('hD), 2'd1});
      vecs.push_back('{1'b0, 1'b0, W'(0), 1'b1, 1'b1, 1'b0, W'(0), 2'd0});

      // reset held for three cycles with input offered
      for (int c = 0; c < 3; c++) begin
         applyStimulus(1'b0, 1'b0, 1'b1, W'('h123), 1'b0);
         checkOutput();
         check("rst.m2.s_ready", W'(if2.s_ready), W'(0));
         check("rst.m2.m_valid", W'(if2.m_valid), W'(0));
         check("rst.m2.count", W'(if2.count), W'(0));
         check("rst.m2.pc", W'(if2.m_data[95:64]), W'(PC_RESET));
         check("rst.m1.s_ready", W'(if1.s_ready), W'(0));
         check("rst.m1.pc", W'(if1.m_data[95:64]), W'(PC_RESET));
         advance();
      end
      applyStimulus(1'b1, 1'b0, 1'b0, W'(0), 1'b0);
      checkOutput();
      check("release.m2.s_ready", W'(if2.s_ready), W'(1));
      check("release.m1.s_ready", W'(if1.s_ready), W'(1));
      advance();

      foreach (vecs[i]) begin
         applyStimulus(1'b1, vecs[i].flush, vecs[i].s_valid, vecs[i].s_data, vecs[i].m_ready);
         checkOutput();
         check($sformatf("vec%0d.s_ready", i), W'(if2.s_ready), W'(vecs[i].exp_s_ready));
         check($sformatf("vec%0d.m_valid", i), W'(if2.m_valid), W'(vecs[i].exp_m_valid));
         check($sformatf("vec%0d.count", i), W'(if2.count), W'(vecs[i].exp_count));
         if (vecs[i].exp_m_valid) begin
            check($sformatf("vec%0d.m_data", i), if2.m_data, vecs[i].exp_m_data);
         end
         advance();
      end

      // MODE 1 half-rate: upstream offers 1..4, one item every two cycles
      for (int c = 0; c < 8; c++) begin
         applyStimulus(1'b1, 1'b0, 1'b1, W'(c / 2 + 1), 1'b1);
         checkOutput();
         check($sformatf("m1thr%0d.s_ready", c), W'(if1.s_ready), W'(c % 2 == 0));
         check($sformatf("m1thr%0d.m_valid", c), W'(if1.m_valid), W'(c % 2 == 1));
         if (c % 2 == 1) begin
            check($sformatf("m1thr%0d.m_data", c), if1.m_data, W'(c / 2 + 1));
         end
         advance();
      end

      // MODE 0: stalled pass-through, then flush
      applyStimulus(1'b1, 1'b0, 1'b1, W'('h55), 1'b0);
      checkOutput();
      check("m0stall.s_ready", W'(if0.s_ready), W'(0));
      check("m0stall.m_valid", W'(if0.m_valid), W'(1));
      check("m0stall.m_data", if0.m_data, W'('h55));
      advance();
      applyStimulus(1'b1, 1'b1, 1'b1, W'('h66), 1'b0);
      checkOutput();
      check("m0flush.m_valid", W'(if0.m_valid), W'(0));
      check("m0flush.s_ready", W'(if0.s_ready), W'(1));
      advance();

      // randomized traffic, including occasional flush and reset
      for (int c = 0; c < 600; c++) begin
         applyStimulus($urandom_range(0, 49) != 0,
                       $urandom_range(0, 11) == 0,
                       $urandom_range(0, 3) != 0,
                       {$urandom, $urandom, $urandom},
                       $urandom_range(0, 2) != 0);
         checkOutput();
         advance();
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
